// File: rtl/collide_accum_stream_if.sv
// Stream, read-port and summary signals of the collision/occupancy accumulator.
// master drives beats and reads; slave is the accumulator itself.
interface collide_accum_stream_if #(
    parameter int WORD_W = 64,
    parameter int ADDR_W = 7,
    parameter int CNT_W  = 16
);
    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_addr;
    logic [WORD_W-1:0] in_data;
    logic              in_last;
    logic              mode;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [WORD_W-1:0] rd_data;
    logic              hit_valid;
    logic              hit_flag;
    logic [CNT_W-1:0]  hit_count;
    logic [ADDR_W-1:0] hit_first_addr;
    logic              busy;

    modport master (
        output clear, in_valid, in_addr, in_data, in_last, mode, rd_en, rd_addr,
        input  in_ready, rd_data, hit_valid, hit_flag, hit_count, hit_first_addr, busy
    );

    modport slave (
        input  clear, in_valid, in_addr, in_data, in_last, mode, rd_en, rd_addr,
        output in_ready, rd_data, hit_valid, hit_flag, hit_count, hit_first_addr, busy
    );
endinterface

// File: rtl/collide_accum_stream.sv
// Word-streamed occupancy map: ORs or collision-checks grid frames against DEPTH words.
// state | meaning: IDLE waiting for frame / RUN frame open / CLEAR sweeping map to zero
module collide_accum_stream #(
    parameter int WORD_W = 64,
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 7,
    parameter int CNT_W  = 16
) (
    input  logic                  CLK,
    input  logic                  RST_n,
    collide_accum_stream_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, CLEAR} state_t;

    localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] map_q [DEPTH];
    logic [ADDR_W-1:0] ptr_q;
    logic              mode_q;
    logic              in_ready_q;
    logic              busy_q;
    logic              hit_valid_q;
    logic              hit_flag_q;
    logic [CNT_W-1:0]  hit_count_q;
    logic [ADDR_W-1:0] hit_first_addr_q;
    logic [WORD_W-1:0] rd_data_q;

    logic              accept;
    logic              in_range;
    logic              rd_in_range;
    logic              first_beat;
    logic              eff_mode;
    logic              collide;
    logic [WORD_W-1:0] cur_word;

    // clear wins over a beat presented in the same cycle
    assign bus.in_ready       = in_ready_q & ~bus.clear;
    assign bus.busy           = busy_q;
    assign bus.hit_valid      = hit_valid_q;
    assign bus.hit_flag       = hit_flag_q;
    assign bus.hit_count      = hit_count_q;
    assign bus.hit_first_addr = hit_first_addr_q;
    assign bus.rd_data        = rd_data_q;

    always_comb begin
        accept      = bus.in_valid & bus.in_ready;
        in_range    = {1'b0, bus.in_addr} < DEPTH_C;
        rd_in_range = {1'b0, bus.rd_addr} < DEPTH_C;
        first_beat  = (state_q == IDLE);
        eff_mode    = first_beat ? bus.mode : mode_q;
        cur_word    = '0;
        if (in_range) cur_word = map_q[bus.in_addr];
        collide     = in_range & (|(cur_word & bus.in_data));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.clear) state_d = CLEAR;
                else if (accept && !bus.in_last) state_d = RUN;
            end
            RUN: begin
                if (bus.clear) state_d = CLEAR;
                else if (accept && bus.in_last) state_d = IDLE;
            end
            CLEAR: begin
                if (!bus.clear && ptr_q == LAST_PTR) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q          <= IDLE;
            for (int i = 0; i < DEPTH; i++) map_q[i] <= '0;
            ptr_q            <= '0;
            mode_q           <= 1'b0;
            in_ready_q       <= 1'b0;
            busy_q           <= 1'b0;
            hit_valid_q      <= 1'b0;
            hit_flag_q       <= 1'b0;
            hit_count_q      <= '0;
            hit_first_addr_q <= '0;
            rd_data_q        <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != CLEAR);
            busy_q      <= (state_d != IDLE);
            hit_valid_q <= accept & bus.in_last;

            // a clear arriving mid-sweep restarts from word 0
            if (bus.clear) begin
                ptr_q <= '0;
            end else if (state_q == CLEAR) begin
                map_q[ptr_q] <= '0;
                ptr_q        <= ptr_q + 1'b1;
            end

            if (accept) begin
                if (first_beat) mode_q <= bus.mode;
                if (in_range && !eff_mode) map_q[bus.in_addr] <= cur_word | bus.in_data;
                if (first_beat) begin
                    hit_flag_q       <= collide;
                    hit_count_q      <= {{(CNT_W-1){1'b0}}, collide};
                    hit_first_addr_q <= collide ? bus.in_addr : '0;
                end else if (collide) begin
                    hit_flag_q <= 1'b1;
                    if (hit_count_q != CNT_MAX) hit_count_q <= hit_count_q + 1'b1;
                    if (!hit_flag_q) hit_first_addr_q <= bus.in_addr;
                end
            end

            if (bus.rd_en) begin
                if (rd_in_range) rd_data_q <= map_q[bus.rd_addr];
                else             rd_data_q <= '0;
            end
        end
    end
endmodule

// File: tb/tb_collide_accum_stream.sv
// Scoreboard bench for collide_accum_stream: reference map model, summary and read queues.
module tb_collide_accum_stream;
    typedef struct {
        logic        flag;
        logic [15:0] cnt;
        logic [6:0]  first;
    } sum_t;

    logic CLK;
    logic RST_n;

    collide_accum_stream_if #(.WORD_W(64), .ADDR_W(7), .CNT_W(16)) bi ();
    collide_accum_stream_if #(.WORD_W(64), .ADDR_W(7), .CNT_W(16)) bs ();

    collide_accum_stream #(.WORD_W(64), .DEPTH(128), .ADDR_W(7), .CNT_W(16)) u_dut (
        .CLK(CLK), .RST_n(RST_n), .bus(bi)
    );
    collide_accum_stream #(.WORD_W(64), .DEPTH(100), .ADDR_W(7), .CNT_W(16)) u_dut100 (
        .CLK(CLK), .RST_n(RST_n), .bus(bs)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [63:0] mdl [128];
    sum_t        sum_q [$];
    sum_t        sum100_q [$];
    logic [63:0] rd_q [$];

    logic        f_open;
    logic        f_mode;
    logic        f_flag;
    logic [15:0] f_cnt;
    logic [6:0]  f_first;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 128; i++) mdl[i] = '0;
        f_open = 1'b0;
        f_mode = 1'b0;
        f_flag = 1'b0;
        f_cnt  = '0;
        f_first = '0;
    endtask

    always @(negedge CLK) begin
        if (RST_n && bi.hit_valid) begin
            if (sum_q.size() == 0) begin
                chk("hit_unexp", 64'(1), 64'(0));
            end else begin
                sum_t e;
                e = sum_q.pop_front();
                chk("hit_flag",  64'(bi.hit_flag),       64'(e.flag));
                chk("hit_count", 64'(bi.hit_count),      64'(e.cnt));
                chk("hit_first", 64'(bi.hit_first_addr), 64'(e.first));
            end
        end
        if (RST_n && bs.hit_valid) begin
            if (sum100_q.size() == 0) begin
                chk("hit100_unexp", 64'(1), 64'(0));
            end else begin
                sum_t e;
                e = sum100_q.pop_front();
                chk("hit100_flag",  64'(bs.hit_flag),       64'(e.flag));
                chk("hit100_count", 64'(bs.hit_count),      64'(e.cnt));
                chk("hit100_first", 64'(bs.hit_first_addr), 64'(e.first));
            end
        end
    end

    // Tasks start and end 1 time unit after a rising edge.
    task automatic beat(input logic [6:0] a, input logic [63:0] d, input logic last, input logic md);
        int          n;
        logic        col;
        logic [63:0] w;
        sum_t        s;
        bi.in_valid = 1'b1;
        bi.in_addr  = a;
        bi.in_data  = d;
        bi.in_last  = last;
        bi.mode     = md;
        n = 0;
        @(negedge CLK);
        while (!bi.in_ready && n < 300) begin
            n++;
            @(negedge CLK);
        end
        if (!bi.in_ready) begin
            chk("beat_timeout", 64'(0), 64'(1));
        end else begin
            if (!f_open) begin
                f_open  = 1'b1;
                f_mode  = md;
                f_flag  = 1'b0;
                f_cnt   = '0;
                f_first = '0;
            end
            w   = mdl[a];
            col = |(w & d);
            if (col) begin
                if (!f_flag) f_first = a;
                f_flag = 1'b1;
                f_cnt  = f_cnt + 16'd1;
            end
            if (!f_mode) mdl[a] = w | d;
            if (last) begin
                s.flag  = f_flag;
                s.cnt   = f_cnt;
                s.first = f_first;
                sum_q.push_back(s);
                f_open = 1'b0;
            end
        end
        @(posedge CLK);
        #1;
        bi.in_valid = 1'b0;
        bi.in_last  = 1'b0;
    endtask

    task automatic rd(input logic [6:0] a);
        bi.rd_en   = 1'b1;
        bi.rd_addr = a;
        rd_q.push_back(mdl[a]);
        @(posedge CLK);
        #1;
        bi.rd_en = 1'b0;
        @(negedge CLK);
        chk("rd_data", bi.rd_data, rd_q.pop_front());
        @(posedge CLK);
        #1;
    endtask

    task automatic beat100(input logic [6:0] a, input logic [63:0] d, input logic last, input logic md);
        bs.in_valid = 1'b1;
        bs.in_addr  = a;
        bs.in_data  = d;
        bs.in_last  = last;
        bs.mode     = md;
        @(negedge CLK);
        chk("rdy100", 64'(bs.in_ready), 64'(1));
        @(posedge CLK);
        #1;
        bs.in_valid = 1'b0;
        bs.in_last  = 1'b0;
    endtask

    initial begin
        int          n;
        logic [63:0] old_w;
        sum_t        s;

        RST_n = 1'b0;
        bi.clear = 0; bi.in_valid = 0; bi.in_addr = '0; bi.in_data = '0; bi.in_last = 0;
        bi.mode = 0; bi.rd_en = 0; bi.rd_addr = '0;
        bs.clear = 0; bs.in_valid = 0; bs.in_addr = '0; bs.in_data = '0; bs.in_last = 0;
        bs.mode = 0; bs.rd_en = 0; bs.rd_addr = '0;
        model_reset();

        repeat (3) @(posedge CLK);
        #1;
        chk("rst_in_ready",  64'(bi.in_ready), 64'(0));
        chk("rst_busy",      64'(bi.busy), 64'(0));
        chk("rst_hit_valid", 64'(bi.hit_valid), 64'(0));
        chk("rst_hit_count", 64'(bi.hit_count), 64'(0));
        chk("rst_rd_data",   bi.rd_data, 64'(0));
        @(negedge CLK);
        RST_n = 1'b1;
        @(posedge CLK);
        #1;
        chk("post_rst_ready", 64'(bi.in_ready), 64'(1));

        // ACCUM frame, then read back
        beat(7'd3, 64'h0F, 1'b0, 1'b0);
        chk("busy_run", 64'(bi.busy), 64'(1));
        beat(7'd5, 64'hF0, 1'b1, 1'b0);
        rd(7'd3);
        rd(7'd5);
        chk("rd_hold", bi.rd_data, 64'hF0);

        // CHECK frame; mode on later beats must be ignored
        beat(7'd3, 64'h01, 1'b0, 1'b1);
        beat(7'd4, 64'h01, 1'b0, 1'b0);
        beat(7'd5, 64'h10, 1'b1, 1'b0);
        rd(7'd3);
        rd(7'd4);

        // back-to-back beats to one address
        beat(7'd9, 64'h1, 1'b0, 1'b0);
        beat(7'd9, 64'h3, 1'b1, 1'b0);
        rd(7'd9);

        // read-before-write on the accepting edge
        beat(7'd20, 64'h5, 1'b0, 1'b0);
        old_w = mdl[20];
        bi.rd_en = 1'b1;
        bi.rd_addr = 7'd20;
        beat(7'd20, 64'hA, 1'b1, 1'b0);
        bi.rd_en = 1'b0;
        @(negedge CLK);
        chk("rd_rbw", bi.rd_data, old_w);
        @(posedge CLK);
        #1;
        rd(7'd20);

        // random short frames over a small address window
        for (int f = 0; f < 8; f++) begin
            int   len;
            logic md;
            len = $urandom_range(1, 4);
            md  = 1'($urandom_range(0, 1));
            for (int b = 0; b < len; b++) begin
                beat(7'($urandom_range(0, 15)),
                     (64'(1) << $urandom_range(0, 15)) | (64'(1) << $urandom_range(0, 15)),
                     (b == len - 1), md);
            end
        end
        for (int a = 0; a < 16; a++) rd(7'(a));

        // clear mid-frame: abort, drop the concurrent beat, sweep DEPTH cycles
        beat(7'd1, 64'hFF, 1'b0, 1'b0);
        beat(7'd2, 64'hFF, 1'b0, 1'b0);
        bi.clear = 1'b1;
        bi.in_valid = 1'b1;
        bi.in_addr = 7'd7;
        bi.in_data = 64'hFFFF;
        bi.in_last = 1'b1;
        @(negedge CLK);
        chk("rdy_on_clear", 64'(bi.in_ready), 64'(0));
        @(posedge CLK);
        #1;
        bi.clear = 1'b0;
        bi.in_valid = 1'b0;
        bi.in_last = 1'b0;
        model_reset();
        n = 0;
        @(negedge CLK);
        chk("busy_clear", 64'(bi.busy), 64'(1));
        while (!bi.in_ready && n < 400) begin
            n++;
            @(negedge CLK);
        end
        chk("clear_cycles", 64'(n), 64'(128));
        @(posedge CLK);
        #1;
        for (int a = 0; a < 128; a++) rd(7'(a));

        // async reset off-edge in the middle of a frame
        beat(7'd10, 64'hAA, 1'b0, 1'b0);
        beat(7'd10, 64'h0A, 1'b0, 1'b0);
        rd(7'd10);
        #2;
        RST_n = 1'b0;
        #1;
        chk("arst_hit_flag",  64'(bi.hit_flag), 64'(0));
        chk("arst_hit_count", 64'(bi.hit_count), 64'(0));
        chk("arst_hit_first", 64'(bi.hit_first_addr), 64'(0));
        chk("arst_rd_data",   bi.rd_data, 64'(0));
        chk("arst_busy",      64'(bi.busy), 64'(0));
        chk("arst_in_ready",  64'(bi.in_ready), 64'(0));
        model_reset();
        @(negedge CLK);
        RST_n = 1'b1;
        @(posedge CLK);
        #1;
        rd(7'd10);
        beat(7'd10, 64'h1, 1'b0, 1'b0);
        beat(7'd10, 64'h1, 1'b1, 1'b0);
        rd(7'd11);

        // DEPTH=100 instance: out-of-range beats accepted but inert
        s.flag = 1'b0; s.cnt = 16'd0; s.first = 7'd0;
        sum100_q.push_back(s);
        beat100(7'd120, 64'hFF, 1'b1, 1'b0);
        sum100_q.push_back(s);
        beat100(7'd99, 64'hFF, 1'b0, 1'b0);
        beat100(7'd120, 64'hFF, 1'b1, 1'b0);
        s.flag = 1'b1; s.cnt = 16'd1; s.first = 7'd99;
        sum100_q.push_back(s);
        beat100(7'd120, 64'hFF, 1'b0, 1'b1);
        beat100(7'd99, 64'h01, 1'b1, 1'b0);
        bs.rd_en = 1'b1;
        bs.rd_addr = 7'd99;
        @(posedge CLK);
        #1;
        bs.rd_addr = 7'd120;
        @(negedge CLK);
        chk("rd100_99", bs.rd_data, 64'hFF);
        @(posedge CLK);
        #1;
        bs.rd_en = 1'b0;
        @(negedge CLK);
        chk("rd100_oor", bs.rd_data, 64'h0);

        repeat (4) @(posedge CLK);
        #1;
        chk("sb_empty",    64'(sum_q.size()), 64'(0));
        chk("sb100_empty", 64'(sum100_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
